// File: rtl/arb_seq_gen_if.sv
// Control/table-write/status bundle for arb_seq_gen.
// ARB_SEQ_ONESHOT_EN adds the oneshot, restart and done signals.
interface arb_seq_gen_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             enable;
  logic             dir;
  logic             len_we;
  logic [AW-1:0]    len_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] seq_out;
  logic [AW-1:0]    index;
  logic             wrap;
`ifdef ARB_SEQ_ONESHOT_EN
  logic             oneshot;
  logic             restart;
  logic             done;

  modport master (
    output enable, dir, len_we, len_data, wr_en, wr_addr, wr_data, oneshot, restart,
    input  seq_out, index, wrap, done
  );
  modport slave (
    input  enable, dir, len_we, len_data, wr_en, wr_addr, wr_data, oneshot, restart,
    output seq_out, index, wrap, done
  );
`else
  modport master (
    output enable, dir, len_we, len_data, wr_en, wr_addr, wr_data,
    input  seq_out, index, wrap
  );
  modport slave (
    input  enable, dir, len_we, len_data, wr_en, wr_addr, wr_data,
    output seq_out, index, wrap
  );
`endif
endinterface

// File: rtl/arb_seq_gen.sv
// Programmable arbitrary-sequence generator: an index counter with a programmable
// wrap point steps through a writable code table. ARB_SEQ_ONESHOT_EN adds stop-at-end.
module arb_seq_gen #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input logic          clock,
  input logic          reset,
  arb_seq_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] tbl [DEPTH];
  logic [AW-1:0]    idx_q, idx_d, last_q, nxt;
  logic             wrap_q, wrap_d, hit;
`ifdef ARB_SEQ_ONESHOT_EN
  logic             done_q, done_d;
`endif

  // hit marks a step that would leave the [0, last] window, i.e. a wrap step
  always_comb begin
    if (bus.dir) begin
      hit = (idx_q == '0) || (idx_q > last_q);
      nxt = hit ? last_q : idx_q - 1'b1;
    end else begin
      hit = (idx_q >= last_q);
      nxt = hit ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
`ifdef ARB_SEQ_ONESHOT_EN
    done_d = done_q;
    if (bus.restart) begin
      idx_d  = bus.dir ? last_q : '0;
      done_d = 1'b0;
    end else if (bus.enable && !done_q) begin
      if (hit && bus.oneshot) begin
        done_d = 1'b1;
      end else begin
        idx_d  = nxt;
        wrap_d = hit;
      end
    end
`else
    if (bus.enable) begin
      idx_d  = nxt;
      wrap_d = hit;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      last_q <= LAST_MAX;
      wrap_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WIDTH'(i);
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      if (bus.len_we)
        last_q <= (int'(bus.len_data) > DEPTH - 1) ? LAST_MAX : bus.len_data;
      if (bus.wr_en && (int'(bus.wr_addr) < DEPTH))
        tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef ARB_SEQ_ONESHOT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= done_d;
  end
  assign bus.done = done_q;
`endif

  assign bus.seq_out = tbl[idx_q];
  assign bus.index   = idx_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_arb_seq_gen.sv
// Bench for arb_seq_gen: directed scenarios with literal expectations plus a
// randomized run, all checked each cycle against a behavioural table/index model.
module tb_arb_seq_gen;
  localparam int WIDTH = 3;
  localparam int DEPTH = 8;

  logic clock, reset;
  int   vectors = 0, miscompares = 0;
  bit   chk_on = 0;

  arb_seq_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  arb_seq_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural model
  int m_tbl [DEPTH];
  int m_idx, m_last;
  bit m_wrap, m_done;

  always @(posedge clock or negedge reset) begin : model
    bit hit;
    int nxt;
    if (!reset) begin
      m_idx = 0; m_last = DEPTH - 1; m_wrap = 0; m_done = 0;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % (1 << WIDTH);
    end else begin
      hit = bus.dir ? (m_idx == 0 || m_idx > m_last) : (m_idx >= m_last);
      if (hit) nxt = bus.dir ? m_last : 0;
      else     nxt = bus.dir ? m_idx - 1 : m_idx + 1;
      m_wrap = 0;
`ifdef ARB_SEQ_ONESHOT_EN
      if (bus.restart) begin
        m_idx = bus.dir ? m_last : 0; m_done = 0;
      end else if (bus.enable && !m_done) begin
        if (hit && bus.oneshot) m_done = 1;
        else begin m_idx = nxt; m_wrap = hit; end
      end
`else
      if (bus.enable) begin m_idx = nxt; m_wrap = hit; end
`endif
      if (bus.len_we) m_last = (int'(bus.len_data) > DEPTH - 1) ? DEPTH - 1 : int'(bus.len_data);
      if (bus.wr_en && int'(bus.wr_addr) < DEPTH) m_tbl[bus.wr_addr] = int'(bus.wr_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on && reset === 1'b1) begin
      chk("seq_out", int'(bus.seq_out), m_tbl[m_idx]);
      chk("index",   int'(bus.index),   m_idx);
      chk("wrap",    int'(bus.wrap),    int'(m_wrap));
`ifdef ARB_SEQ_ONESHOT_EN
      chk("done",    int'(bus.done),    int'(m_done));
`endif
    end
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic idle_inputs();
    bus.enable = 0; bus.dir = 0; bus.len_we = 0; bus.len_data = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef ARB_SEQ_ONESHOT_EN
    bus.oneshot = 0; bus.restart = 0;
`endif
  endtask

  // async reset dropped mid-cycle; state must clear before any clock edge
  task automatic do_reset();
    @(posedge clock); #4 reset = 0; #1;
    chk("rst_index", int'(bus.index), 0);
    chk("rst_seq",   int'(bus.seq_out), 0);
    chk("rst_wrap",  int'(bus.wrap), 0);
`ifdef ARB_SEQ_ONESHOT_EN
    chk("rst_done",  int'(bus.done), 0);
`endif
    idle_inputs();
    @(posedge clock); #2 reset = 1;
  endtask

  task automatic rand_inputs();
    bus.enable   = ($urandom_range(0, 3) != 0);
    bus.dir      = ($urandom_range(0, 3) == 0);
    bus.len_we   = ($urandom_range(0, 15) == 0);
    bus.len_data = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(0, DEPTH - 1);
    bus.wr_en    = ($urandom_range(0, 7) == 0);
    bus.wr_addr  = $urandom_range(0, DEPTH - 1);
    bus.wr_data  = $urandom_range(0, (1 << WIDTH) - 1);
`ifdef ARB_SEQ_ONESHOT_EN
    if ($urandom_range(0, 31) == 0) bus.oneshot = ~bus.oneshot;
    bus.restart  = ($urandom_range(0, 19) == 0);
`endif
  endtask

  int pat  [7] = '{0, 1, 2, 3, 6, 5, 7};
  int down [8] = '{7, 5, 6, 3, 2, 1, 0, 7};

  initial begin
    reset = 0;
    idle_inputs();
    tick(); tick();
    reset = 1;
    chk_on = 1;

    // 1: reset mid-run, then free-running up count
    bus.enable = 1;
    repeat (13) tick();
    do_reset();
    bus.enable = 1;
    for (int k = 0; k < 10; k++) begin
      chk("t1_seq", int'(bus.seq_out), k % 8);
      tick();
    end
    bus.enable = 0;

    // 2: custom table, last index 6
    do_reset();
    for (int e = 0; e < 7; e++) begin
      bus.wr_en = 1; bus.wr_addr = e; bus.wr_data = pat[e];
      tick();
    end
    bus.wr_en = 0;
    bus.len_we = 1; bus.len_data = 6;
    tick();
    bus.len_we = 0;
    bus.enable = 1; bus.dir = 0;
    for (int k = 0; k < 14; k++) begin
      chk("t2_seq", int'(bus.seq_out), pat[k % 7]);
      tick();
      chk("t2_wrap", int'(bus.wrap), int'((k % 7) == 6));
    end
    chk("t2_seq_end", int'(bus.seq_out), 0);

    // 3: down from index 0
    bus.dir = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t3_seq", int'(bus.seq_out), down[k]);
      chk("t3_wrap", int'(bus.wrap), int'(k == 0 || k == 7));
    end

    // 4: length change in the same cycle as a step uses the old last index
    tick();
    chk("t4_idx5", int'(bus.index), 5);
    bus.dir = 0; bus.len_we = 1; bus.len_data = 2;
    tick();
    bus.len_we = 0;
    chk("t4_idx6", int'(bus.index), 6);
    chk("t4_nowrap", int'(bus.wrap), 0);
    tick();
    chk("t4_idx0", int'(bus.index), 0);
    chk("t4_wrap", int'(bus.wrap), 1);
    bus.enable = 0; bus.len_we = 1; bus.len_data = 7;
    tick();
    bus.len_we = 0;
    tick();
    chk("t4_hold_wrap", int'(bus.wrap), 0);

    // 5: write to the current entry while stepping
    bus.enable = 1; bus.dir = 0;
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 5;
    tick();
    bus.wr_en = 0;
    chk("t5_idx", int'(bus.index), 1);
    chk("t5_seq", int'(bus.seq_out), 1);
    bus.dir = 1;
    tick();
    chk("t5_rewind_idx", int'(bus.index), 0);
    chk("t5_rewind_seq", int'(bus.seq_out), 5);
    bus.enable = 0;

`ifdef ARB_SEQ_ONESHOT_EN
    // 6: oneshot stop and restart
    do_reset();
    bus.oneshot = 1; bus.len_we = 1; bus.len_data = 3;
    tick();
    bus.len_we = 0; bus.enable = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t6_idx", int'(bus.index), k);
      tick();
    end
    chk("t6_hold", int'(bus.index), 3);
    chk("t6_done", int'(bus.done), 1);
    chk("t6_wrap", int'(bus.wrap), 0);
    tick();
    chk("t6_hold2", int'(bus.index), 3);
    bus.restart = 1;
    tick();
    bus.restart = 0;
    chk("t6_restart_idx", int'(bus.index), 0);
    chk("t6_restart_done", int'(bus.done), 0);
    bus.enable = 0; bus.oneshot = 0;
`endif

    // randomized run with occasional async resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rand_inputs();
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
